// File: rtl/tinysoc_imem_loader_if.sv
// Chunk-stream / imem-write bundle for the tinysoc program loader.
// master drives chunks and reload; slave is the loader.
interface tinysoc_imem_loader_if #(
  parameter int CHUNK_W = 5,
  parameter int INSTR_W = 15,
  parameter int ADDR_W  = 4
);
  logic [CHUNK_W-1:0] chunk_in;
  logic               chunk_valid;
  logic               reload;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_waddr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               cpu_run;
  logic               loading;

  modport master (
    output chunk_in,
    output chunk_valid,
    output reload,
    input  imem_we,
    input  imem_waddr,
    input  imem_wdata,
    input  cpu_run,
    input  loading
  );

  modport slave (
    input  chunk_in,
    input  chunk_valid,
    input  reload,
    output imem_we,
    output imem_waddr,
    output imem_wdata,
    output cpu_run,
    output loading
  );
endinterface

// File: rtl/tinysoc_imem_loader.sv
// tinysoc program loader: assembles pin chunks into instructions,
// fills imem 0..DEPTH-1, then releases the core.
module tinysoc_imem_loader #(
  parameter int CHUNK_W    = 5,
  parameter int INSTR_W    = 15,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int VALID_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tinysoc_imem_loader_if.slave   bus
);

  localparam int CHUNKS = (INSTR_W + CHUNK_W - 1) / CHUNK_W;
  localparam int BUF_W  = CHUNKS * CHUNK_W;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0]  LAST_CHUNK = CNT_W'(CHUNKS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_LOAD,
    S_RUN
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nx;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  w_addr_nx;
  logic [BUF_W-1:0]   r_buf;
  logic [BUF_W-1:0]   w_buf_nx;
  logic [BUF_W-1:0]   w_fill;
  logic               r_we;
  logic               w_we_nx;
  logic [ADDR_W-1:0]  r_waddr;
  logic [ADDR_W-1:0]  w_waddr_nx;
  logic [INSTR_W-1:0] r_wdata;
  logic [INSTR_W-1:0] w_wdata_nx;
  logic               r_run;
  logic               w_run_nx;
  logic               r_load;
  logic               w_load_nx;
  logic               w_acc;
  logic               w_unused;

  assign w_acc = (r_state == S_LOAD) && !bus.reload &&
                 ((VALID_MODE == 0) || bus.chunk_valid);

  // Bits of the final chunk beyond INSTR_W never reach imem.
  assign w_unused = ^w_fill;

  always_comb begin
    w_fill = r_buf;
    for (int k = 0; k < CHUNKS; k++) begin
      if (r_cnt == CNT_W'(k)) begin
        w_fill[k*CHUNK_W +: CHUNK_W] = bus.chunk_in;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_addr_nx  = r_addr;
    w_buf_nx   = r_buf;
    w_we_nx    = 1'b0;
    w_waddr_nx = r_waddr;
    w_wdata_nx = r_wdata;
    unique case (1'b1)
      bus.reload: begin
        w_state_nx = S_LOAD;
        w_cnt_nx   = '0;
        w_addr_nx  = '0;
        w_buf_nx   = '0;
      end
      w_acc: begin
        if (r_cnt == LAST_CHUNK) begin
          w_cnt_nx   = '0;
          w_buf_nx   = '0;
          w_we_nx    = 1'b1;
          w_waddr_nx = r_addr;
          w_wdata_nx = w_fill[INSTR_W-1:0];
          if (r_addr == LAST_ADDR) begin
            w_addr_nx  = '0;
            w_state_nx = S_RUN;
          end else begin
            w_addr_nx = r_addr + 1'b1;
          end
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
          w_buf_nx = w_fill;
        end
      end
      default: ;
    endcase
    // Status outputs trail the state by one edge so cpu_run rises
    // the cycle after the final write strobe.
    w_run_nx  = !bus.reload && (r_state == S_RUN);
    w_load_nx = !w_run_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_buf   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_run   <= 1'b0;
      r_load  <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_addr  <= w_addr_nx;
      r_buf   <= w_buf_nx;
      r_we    <= w_we_nx;
      r_waddr <= w_waddr_nx;
      r_wdata <= w_wdata_nx;
      r_run   <= w_run_nx;
      r_load  <= w_load_nx;
    end
  end

  assign bus.imem_we    = r_we;
  assign bus.imem_waddr = r_waddr;
  assign bus.imem_wdata = r_wdata;
  assign bus.cpu_run    = r_run;
  assign bus.loading    = r_load;

endmodule
